// File: rtl/alu_stack_sequencer_if.sv
// Command/ALU/status bundle between the instruction decoder, the shared ALU
// and the stack sequencer. The master side is the environment (decoder + ALU)
// and the slave side is the sequencer.
interface alu_stack_sequencer_if #(
    parameter int CNT_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [3:0]        cmd_alu_op;
    logic [31:0]       cmd_data;
    logic [3:0]        alu_ctrl;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [31:0]       alu_result;
    logic              top_valid;
    logic [31:0]       top_data;
    logic [CNT_W-1:0]  depth_count;
    logic              err;
    logic [1:0]        err_code;
    logic              err_clr;

    modport master (
        output cmd_valid, cmd_kind, cmd_alu_op, cmd_data, alu_result, err_clr,
        input  cmd_ready, alu_ctrl, alu_a, alu_b, top_valid, top_data,
               depth_count, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_alu_op, cmd_data, alu_result, err_clr,
        output cmd_ready, alu_ctrl, alu_a, alu_b, top_valid, top_data,
               depth_count, err, err_code
    );
endinterface

// File: rtl/alu_stack_sequencer.sv
// Stack-machine sequencer for a shared combinational 32-bit ALU.
// Accepts PUSH/POP/ALU/NOP commands, feeds ALU operands from the stack top
// and writes the ALU result back. ALU commands take IDLE -> EXEC -> WB.
// Optional feature: define ALU_DIV_ZERO_CHECK_EN to reject divide-by-zero
// (opcode 3 with T==0, opcode 4 with N==0) at accept time.
module alu_stack_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_stack_sequencer_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [1:0] K_PUSH = 2'd1;
    localparam logic [1:0] K_POP  = 2'd2;
    localparam logic [1:0] K_ALU  = 2'd3;

    localparam logic [1:0] E_NONE = 2'd0;
    localparam logic [1:0] E_OVF  = 2'd1;
    localparam logic [1:0] E_UNF  = 2'd2;
    localparam logic [1:0] E_ILL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_new_cnt;
    logic [PTR_W-1:0]      r_wr_idx;
    logic [3:0]            r_alu_ctrl;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [DATA_W-1:0]     r_res;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [DATA_W-1:0]     r_stack [DEPTH];

    logic                  w_accept;
    logic                  w_unary;
    logic                  w_few;
    logic                  w_div0;
    logic                  w_full;
    logic                  w_empty;
    logic [PTR_W-1:0]      w_top_idx;
    logic [PTR_W-1:0]      w_nxt_idx;
    logic [PTR_W-1:0]      w_push_idx;
    logic [DATA_W-1:0]     w_top;
    logic [DATA_W-1:0]     w_nxt;
    logic [1:0]            w_err_code;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_alu_go;

    // Decode the offered command against the current stack state.
    always_comb begin
        w_accept   = bus.cmd_valid & r_ready;
        w_full     = (r_cnt == CNT_W'(DEPTH));
        w_empty    = (r_cnt == '0);
        w_top_idx  = PTR_W'(r_cnt - CNT_W'(1));
        w_nxt_idx  = PTR_W'(r_cnt - CNT_W'(2));
        w_push_idx = PTR_W'(r_cnt);
        w_top      = r_stack[w_top_idx];
        w_nxt      = r_stack[w_nxt_idx];
        w_unary    = (bus.cmd_alu_op == 4'd7) || (bus.cmd_alu_op == 4'd8);
        w_few      = w_unary ? w_empty : (r_cnt < CNT_W'(2));
`ifdef ALU_DIV_ZERO_CHECK_EN
        w_div0     = ((bus.cmd_alu_op == 4'd3) && (w_top == '0)) ||
                     ((bus.cmd_alu_op == 4'd4) && (w_nxt == '0));
`else
        w_div0     = 1'b0;
`endif
        w_err_code = E_NONE;
        w_push_ok  = 1'b0;
        w_pop_ok   = 1'b0;
        w_alu_go   = 1'b0;
        if (w_accept) begin
            case (bus.cmd_kind)
                K_PUSH: begin
                    if (w_full) w_err_code = E_OVF;
                    else        w_push_ok  = 1'b1;
                end
                K_POP: begin
                    if (w_empty) w_err_code = E_UNF;
                    else         w_pop_ok   = 1'b1;
                end
                K_ALU: begin
                    if (bus.cmd_alu_op == 4'd15) w_err_code = E_ILL;
                    else if (w_few)              w_err_code = E_UNF;
                    else if (w_div0)             w_err_code = E_ILL;
                    else                         w_alu_go   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control FSM: state, handshake, depth, error flag and registered ALU drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_cnt      <= '0;
            r_new_cnt  <= '0;
            r_wr_idx   <= '0;
            r_alu_ctrl <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
        end else begin
            // First error is kept; a clear in the same cycle as a new error lets the new one in.
            if (w_err_code != E_NONE) begin
                if (!r_err || bus.err_clr) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code;
                end
            end else if (bus.err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= E_NONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_push_ok) r_cnt <= r_cnt + CNT_W'(1);
                    if (w_pop_ok)  r_cnt <= r_cnt - CNT_W'(1);
                    if (w_alu_go) begin
                        r_alu_ctrl <= bus.cmd_alu_op;
                        if (w_unary) begin
                            r_alu_a   <= w_top;
                            r_alu_b   <= '0;
                            r_new_cnt <= r_cnt;
                            r_wr_idx  <= w_top_idx;
                        end else begin
                            r_alu_a   <= w_nxt;
                            r_alu_b   <= w_top;
                            r_new_cnt <= r_cnt - CNT_W'(1);
                            r_wr_idx  <= w_nxt_idx;
                        end
                        r_state <= S_EXEC;
                        r_ready <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_cnt   <= r_new_cnt;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stack storage and ALU result capture; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_stack[w_push_idx] <= bus.cmd_data;
        if (r_state == S_EXEC) r_res <= bus.alu_result;
        if (r_state == S_WB) r_stack[r_wr_idx] <= r_res;
    end

    assign bus.cmd_ready   = r_ready;
    assign bus.alu_ctrl    = r_alu_ctrl;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.top_valid   = ~w_empty;
    assign bus.top_data    = w_empty ? '0 : w_top;
    assign bus.depth_count = r_cnt;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Bench for alu_stack_sequencer: directed scenarios plus randomized command
// streams checked against a queue-based stack model with its own ALU model.
module tb_alu_stack_sequencer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_stk[$];
    logic        m_err;
    logic [1:0]  m_code;

    always #5 clk = ~clk;

    alu_stack_sequencer_if #(.CNT_W(CNT_W)) ifc ();

    alu_stack_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // ALU model: 7 is logical not, 8 is bitwise invert, divides saturate on zero divisor.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd4:  return (a == 0) ? 32'hFFFF_FFFF : b / a;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return {31'd0, a == 0};
            4'd8:  return ~a;
            4'd9:  return a ^ b;
            4'd10: return a << b[4:0];
            4'd11: return a >> b[4:0];
            4'd12: return {31'd0, a < b};
            4'd13: return {31'd0, a == b};
            4'd14: return (a > b) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    assign ifc.alu_result = alu_f(ifc.alu_ctrl, ifc.alu_a, ifc.alu_b);

    function automatic logic div0_rej(input logic [3:0] op, input logic [31:0] t, input logic [31:0] n);
`ifdef ALU_DIV_ZERO_CHECK_EN
        return ((op == 4'd3) && (t == 0)) || ((op == 4'd4) && (n == 0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: apply one accepted command to the abstract stack.
    task automatic m_apply(input logic [1:0] k, input logic [3:0] op, input logic [31:0] d,
                           input logic clr, output logic go, output logic [31:0] ea, output logic [31:0] eb);
        int          n;
        logic [1:0]  ec;
        logic [31:0] t, nn;
        logic        bin;
        n  = m_stk.size();
        ec = 2'd0; go = 1'b0; ea = '0; eb = '0;
        t  = (n >= 1) ? m_stk[n-1] : 32'd0;
        nn = (n >= 2) ? m_stk[n-2] : 32'd0;
        bin = !((op == 4'd7) || (op == 4'd8));
        case (k)
            2'd1: if (n == DEPTH) ec = 2'd1; else m_stk.push_back(d);
            2'd2: if (n == 0) ec = 2'd2; else void'(m_stk.pop_back());
            2'd3: begin
                if (op == 4'd15) ec = 2'd3;
                else if (n < (bin ? 2 : 1)) ec = 2'd2;
                else if (div0_rej(op, t, nn)) ec = 2'd3;
                else begin
                    go = 1'b1;
                    if (bin) begin
                        ea = nn; eb = t;
                        void'(m_stk.pop_back());
                        void'(m_stk.pop_back());
                    end else begin
                        ea = t; eb = 32'd0;
                        void'(m_stk.pop_back());
                    end
                    m_stk.push_back(alu_f(op, ea, eb));
                end
            end
            default: ;
        endcase
        if (ec != 0) begin
            if (!m_err || clr) begin
                m_err = 1'b1; m_code = ec;
            end
        end else if (clr) begin
            m_err = 1'b0; m_code = 2'd0;
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = m_stk.size();
        chk({tag, "_cnt"},  ifc.depth_count, n);
        chk({tag, "_tv"},   ifc.top_valid, (n != 0));
        chk({tag, "_top"},  ifc.top_data, (n != 0) ? m_stk[n-1] : 32'd0);
        chk({tag, "_err"},  ifc.err, m_err);
        chk({tag, "_code"}, ifc.err_code, m_code);
    endtask

    task automatic issue(input logic [1:0] k, input logic [3:0] op, input logic [31:0] d, input logic clr);
        logic        go;
        logic [31:0] ea, eb;
        int          old_cnt;
        int          w;
        w = 0;
        while (!ifc.cmd_ready && w < 8) begin
            @(posedge clk); #1; w++;
        end
        if (!ifc.cmd_ready) chk("ready_wait", ifc.cmd_ready, 1);
        old_cnt = m_stk.size();
        m_apply(k, op, d, clr, go, ea, eb);
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_kind   = k;
        ifc.cmd_alu_op = op;
        ifc.cmd_data   = d;
        ifc.err_clr    = clr;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        ifc.err_clr   = 1'b0;
        if (go) begin
            chk("exec_ready", ifc.cmd_ready, 0);
            chk("exec_a", ifc.alu_a, ea);
            chk("exec_b", ifc.alu_b, eb);
            chk("exec_ctrl", ifc.alu_ctrl, op);
            chk("exec_cnt", ifc.depth_count, old_cnt);
            @(posedge clk); #1;
            chk("wb_ready", ifc.cmd_ready, 0);
            @(posedge clk); #1;
        end
        chk("idle_ready", ifc.cmd_ready, 1);
        check_state("st");
    endtask

    task automatic drain();
        while (m_stk.size() != 0) issue(2'd2, 4'd0, 32'd0, 1'b0);
        issue(2'd0, 4'd0, 32'd0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        go;
        logic [31:0] ea, eb;
        int          acc;
        int          r;
        logic [1:0]  k;

        rst_n = 1'b0;
        ifc.cmd_valid = 1'b0; ifc.cmd_kind = 2'd0; ifc.cmd_alu_op = 4'd0;
        ifc.cmd_data = 32'd0; ifc.err_clr = 1'b0;
        m_err = 1'b0; m_code = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ready", ifc.cmd_ready, 1);
        chk("rst_cnt", ifc.depth_count, 0);
        chk("rst_tv", ifc.top_valid, 0);
        chk("rst_top", ifc.top_data, 0);
        chk("rst_ctrl", ifc.alu_ctrl, 0);
        chk("rst_a", ifc.alu_a, 0);
        chk("rst_b", ifc.alu_b, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_code", ifc.err_code, 0);

        // SUB: 6 - 2
        issue(2'd1, 4'd0, 32'd6, 1'b0);
        issue(2'd1, 4'd0, 32'd2, 1'b0);
        issue(2'd3, 4'd1, 32'd0, 1'b0);
        chk("sub_a", ifc.alu_a, 6);
        chk("sub_b", ifc.alu_b, 2);
        chk("sub_top", ifc.top_data, 4);
        chk("sub_cnt", ifc.depth_count, 1);

        // Unary ops
        drain();
        issue(2'd1, 4'd0, 32'd5, 1'b0);
        issue(2'd3, 4'd7, 32'd0, 1'b0);
        chk("not_top", ifc.top_data, 0);
        chk("not_cnt", ifc.depth_count, 1);
        issue(2'd3, 4'd8, 32'd0, 1'b0);
        chk("neg_top", ifc.top_data, 32'hFFFF_FFFF);

        // Overflow, then underflow keeps the first code, then clear
        drain();
        for (int i = 0; i <= DEPTH; i++) issue(2'd1, 4'd0, 32'(i + 100), 1'b0);
        chk("ovf_cnt", ifc.depth_count, DEPTH);
        chk("ovf_err", ifc.err, 1);
        chk("ovf_code", ifc.err_code, 1);
        for (int i = 0; i <= DEPTH; i++) issue(2'd2, 4'd0, 32'd0, 1'b0);
        chk("unf_code", ifc.err_code, 1);
        issue(2'd0, 4'd0, 32'd0, 1'b1);
        chk("clr_err", ifc.err, 0);

        // Divide by zero
        issue(2'd1, 4'd0, 32'd9, 1'b0);
        issue(2'd1, 4'd0, 32'd0, 1'b0);
        issue(2'd3, 4'd3, 32'd0, 1'b0);
`ifdef ALU_DIV_ZERO_CHECK_EN
        chk("div0_cnt", ifc.depth_count, 2);
        chk("div0_top", ifc.top_data, 0);
        chk("div0_code", ifc.err_code, 3);
`else
        chk("div0_cnt", ifc.depth_count, 1);
        chk("div0_top", ifc.top_data, 32'hFFFF_FFFF);
`endif

        // New error together with err_clr replaces the held code
        drain();
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        chk("pre_code", ifc.err_code, 2);
        issue(2'd3, 4'd15, 32'd0, 1'b1);
        chk("clrnew_code", ifc.err_code, 3);
        issue(2'd0, 4'd0, 32'd0, 1'b1);

        // Backpressure: cmd_valid held high across an ALU op
        issue(2'd1, 4'd0, 32'd3, 1'b0);
        issue(2'd1, 4'd0, 32'd4, 1'b0);
        ifc.cmd_valid = 1'b1; ifc.cmd_kind = 2'd3; ifc.cmd_alu_op = 4'd0; ifc.cmd_data = 32'd0;
        acc = 0;
        for (int e = 0; e < 5; e++) begin
            chk("bp_ready", ifc.cmd_ready, (e == 0 || e >= 3));
            if (ifc.cmd_ready) acc++;
            @(posedge clk); #1;
            if (e == 0) begin
                ifc.cmd_kind = 2'd1; ifc.cmd_data = 32'd77;
            end
        end
        ifc.cmd_valid = 1'b0;
        chk("bp_accepts", acc, 3);
        m_apply(2'd3, 4'd0, 32'd0, 1'b0, go, ea, eb);
        m_apply(2'd1, 4'd0, 32'd77, 1'b0, go, ea, eb);
        m_apply(2'd1, 4'd0, 32'd77, 1'b0, go, ea, eb);
        check_state("bp");

        // Async reset in the middle of EXEC
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        drain();
        issue(2'd2, 4'd0, 32'd0, 1'b0);
        issue(2'd1, 4'd0, 32'd11, 1'b0);
        issue(2'd1, 4'd0, 32'd22, 1'b0);
        ifc.cmd_valid = 1'b1; ifc.cmd_kind = 2'd3; ifc.cmd_alu_op = 4'd0;
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        chk("mid_exec_ready", ifc.cmd_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ifc.cmd_ready, 1);
        chk("mid_rst_cnt", ifc.depth_count, 0);
        chk("mid_rst_err", ifc.err, 0);
        chk("mid_rst_a", ifc.alu_a, 0);
        chk("mid_rst_tv", ifc.top_valid, 0);
        m_stk.delete(); m_err = 1'b0; m_code = 2'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("post_rst");

        // Randomized command stream
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      k = 2'd0;
            else if (r < 7)  k = 2'd1;
            else if (r < 10) k = 2'd2;
            else             k = 2'd3;
            issue(k, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
